hp_bar_renderer: RTL

Parametrised, clocked successor to the fight-scene HP-bar drawing. It holds a per-bar displayed HP that drains or refills toward a target HP at a fixed frame-locked rate, and reports when every bar has settled so the fight FSM can leave its hp-reducing state. It renders the bars as a registered pixel overlay into the scene's VGA colour mux.

---
 rtl/scene_pkg.sv | 24 ++
 rtl/hp_bar_channel.sv | 78 +++++++
 rtl/hp_bar_renderer.sv | 110 +++++++++++
 3 files changed

// File: rtl/scene_pkg.sv
// Shared fight-scene definitions: VGA colour constants and fight/option state codes.
package scene_pkg;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hfff;
    localparam logic [11:0] GREEN  = 12'h0f0;
    localparam logic [11:0] YELLOW = 12'hff0;
    localparam logic [11:0] RED    = 12'hf00;

    typedef enum logic [2:0] {
        FIGHT_IDLE,
        FIGHT_PLAYER_TURN,
        FIGHT_ENEMY_TURN,
        FIGHT_HP_REDUCING,
        FIGHT_DONE
    } fight_state_e;

    typedef enum logic [1:0] {
        OPT_ATTACK,
        OPT_ITEM,
        OPT_MERCY
    } option_e;

endpackage

// File: rtl/hp_bar_channel.sv
// One HP bar: displayed-HP register stepping toward a clamped target, plus its pixel hit/colour test.
module hp_bar_channel
    import scene_pkg::*;
#(
    parameter int HP_W   = 8,
    parameter int HP_MAX = 196,
    parameter int BORDER = 2,
    parameter int BAR_H  = 12,
    parameter int STEP   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HP_W-1:0] target_hp,
    input  logic            snap,
    input  logic            step_evt,
    input  logic            blink,
    input  logic [9:0]      h_cnt,
    input  logic [9:0]      v_cnt,
    input  logic [9:0]      bar_x,
    input  logic [9:0]      bar_y,
    output logic [HP_W-1:0] disp,
    output logic            busy,
    output logic            hit,
    output logic [11:0]     rgb
);

    localparam int MW = HP_W + 3;
    localparam logic [HP_W-1:0] HP_MAX_V = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0] STEP_V   = HP_W'(STEP);
    localparam logic [9:0]      W_V      = 10'(HP_MAX + 2 * BORDER);
    localparam logic [9:0]      BORDER_V = 10'(BORDER);
    localparam logic [9:0]      BAR_H_V  = 10'(BAR_H);

    logic [HP_W-1:0] disp_q, disp_d, tgt;
    logic [9:0]      rx, ry, fx;
    logic [MW-1:0]   dx;
    logic            in_box, on_border;
    logic [11:0]     fill;

    always_comb begin
        tgt    = (target_hp > HP_MAX_V) ? HP_MAX_V : target_hp;
        disp_d = disp_q;
        // The last partial step lands exactly on the target, so no overshoot or wrap.
        if (snap) begin
            disp_d = tgt;
        end else if (step_evt && (disp_q > tgt)) begin
            disp_d = ((disp_q - tgt) > STEP_V) ? (disp_q - STEP_V) : tgt;
        end else if (step_evt && (disp_q < tgt)) begin
            disp_d = ((tgt - disp_q) > STEP_V) ? (disp_q + STEP_V) : tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_q <= HP_MAX_V;
        else     disp_q <= disp_d;
    end

    // Coordinates left of / above the bar wrap to large values and fall outside the box.
    always_comb begin
        rx        = h_cnt - bar_x;
        ry        = v_cnt - bar_y;
        fx        = rx - BORDER_V;
        dx        = MW'(disp_q);
        in_box    = (rx < W_V) && (ry < BAR_H_V);
        on_border = (rx < BORDER_V) || (rx >= W_V - BORDER_V) ||
                    (ry < BORDER_V) || (ry >= BAR_H_V - BORDER_V);
        if (dx * MW'(2) > MW'(HP_MAX))      fill = GREEN;
        else if (dx * MW'(5) > MW'(HP_MAX)) fill = YELLOW;
        else                                fill = blink ? WHITE : RED;
        hit = in_box;
        rgb = BLACK;
        if (in_box && !on_border) rgb = (fx < 10'(disp_q)) ? fill : WHITE;
    end

    assign disp = disp_q;
    assign busy = (disp_q != tgt);

endmodule

// File: rtl/hp_bar_renderer.sv
// HP-bar overlay: frame-locked drain/refill of NUM_BARS bars, settle detection, registered pixel output.
module hp_bar_renderer
    import scene_pkg::*;
#(
    parameter int NUM_BARS     = 2,
    parameter int HP_W         = 8,
    parameter int HP_MAX       = 196,
    parameter int BORDER       = 2,
    parameter int BAR_H        = 12,
    parameter int DRAIN_PERIOD = 2,
    parameter int STEP         = 1,
    parameter int TICK_LINE    = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               h_cnt,
    input  logic [9:0]               v_cnt,
    input  logic [NUM_BARS*HP_W-1:0] target_hp,
    input  logic [NUM_BARS-1:0]      snap,
    input  logic [NUM_BARS*10-1:0]   bar_x,
    input  logic [NUM_BARS*10-1:0]   bar_y,
    output logic [NUM_BARS*HP_W-1:0] disp_hp,
    output logic [NUM_BARS-1:0]      busy,
    output logic                     settled,
    output logic                     pix_hit,
    output logic [11:0]              pix_rgb
);

    localparam int FW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

    logic [9:0]    v_q, v_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    logic [4:0]    blink_cnt_q, blink_cnt_d;
    logic          any_busy_q, any_busy_d;
    logic          pix_hit_q, pix_hit_d;
    logic [11:0]   pix_rgb_q, pix_rgb_d;
    logic          tick, step_evt;

    logic [NUM_BARS-1:0] ch_hit;
    logic [11:0]         ch_rgb [NUM_BARS];

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        hp_bar_channel #(
            .HP_W   (HP_W),
            .HP_MAX (HP_MAX),
            .BORDER (BORDER),
            .BAR_H  (BAR_H),
            .STEP   (STEP)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .target_hp (target_hp[g*HP_W +: HP_W]),
            .snap      (snap[g]),
            .step_evt  (step_evt),
            .blink     (blink_cnt_q[4]),
            .h_cnt     (h_cnt),
            .v_cnt     (v_cnt),
            .bar_x     (bar_x[g*10 +: 10]),
            .bar_y     (bar_y[g*10 +: 10]),
            .disp      (disp_hp[g*HP_W +: HP_W]),
            .busy      (busy[g]),
            .hit       (ch_hit[g]),
            .rgb       (ch_rgb[g])
        );
    end

    always_comb begin
        tick        = (v_cnt == 10'(TICK_LINE)) && (v_q != 10'(TICK_LINE));
        step_evt    = tick && (frm_cnt_q == FW'(DRAIN_PERIOD - 1));
        v_d         = v_cnt;
        frm_cnt_d   = frm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        if (step_evt)  frm_cnt_d = '0;
        else if (tick) frm_cnt_d = frm_cnt_q + FW'(1);
        if (tick) blink_cnt_d = blink_cnt_q + 5'd1;
        any_busy_d = |busy;
        // Walk from the highest index down so the lowest-index hitting bar is the last writer.
        pix_hit_d = 1'b0;
        pix_rgb_d = BLACK;
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if (ch_hit[i]) begin
                pix_hit_d = 1'b1;
                pix_rgb_d = ch_rgb[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            frm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            any_busy_q  <= 1'b0;
            pix_hit_q   <= 1'b0;
            pix_rgb_q   <= BLACK;
        end else begin
            v_q         <= v_d;
            frm_cnt_q   <= frm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            any_busy_q  <= any_busy_d;
            pix_hit_q   <= pix_hit_d;
            pix_rgb_q   <= pix_rgb_d;
        end
    end

    assign settled = any_busy_q && !(|busy);
    assign pix_hit = pix_hit_q;
    assign pix_rgb = pix_rgb_q;

endmodule
